// File: rtl/title_ram_loader.sv
// Unpacks a ready/valid byte stream MSB-first into single-bit title bitmap RAM writes.
// Optional vblank write gate: define TITLE_LOAD_VBLANK_EN.
module title_ram_loader #(
  parameter int ADDR      = 15,
  parameter int V_VISIBLE = 480
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [ADDR-1:0] base_addr,
  input  logic [ADDR:0]   len,
  input  logic [7:0]      s_data,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [10:0]     y,
  output logic            wr_en,
  output logic [ADDR-1:0] wr_addr,
  output logic            wr_data,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [10:0] VVIS = 11'(V_VISIBLE);

  state_t          state_q, state_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [ADDR:0]   rem_q, rem_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [3:0]      bcnt_q, bcnt_d;
  logic            wr_gate;

`ifdef TITLE_LOAD_VBLANK_EN
  assign wr_gate = (y >= VVIS);
`else
  logic unused_vblank;
  assign wr_gate       = 1'b1;
  assign unused_vblank = (y >= VVIS);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      shreg_q <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = len;
          state_d = (len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (s_valid) begin
          shreg_d = s_data;
          bcnt_d  = 4'd8;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // stalled writes leave every counter untouched
        if (wr_gate) begin
          shreg_d = {shreg_q[6:0], 1'b0};
          addr_d  = addr_q + ADDR'(1);
          rem_d   = rem_q - (ADDR+1)'(1);
          bcnt_d  = bcnt_q - 4'd1;
          if (rem_q == (ADDR+1)'(1)) begin
            state_d = DONE;
          end else if (bcnt_q == 4'd1) begin
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    wr_en   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    wr_addr = addr_q;
    wr_data = shreg_q[7];
    unique case (1'b1)
      (state_q == IDLE):  busy    = 1'b0;
      (state_q == FETCH): s_ready = 1'b1;
      (state_q == WRITE): wr_en   = wr_gate;
      (state_q == DONE):  done    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_title_ram_loader.sv
// Bench for title_ram_loader: directed and random loads checked
// against a pixel-list model of the expected RAM writes.
module tb_title_ram_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [14:0] base_addr;
  logic [15:0] len;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [10:0] y;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic        wr_data;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  title_ram_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .y         (y),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_y();
`ifdef TITLE_LOAD_VBLANK_EN
    y = 11'($urandom_range(480, 524));
`else
    y = 11'($urandom_range(0, 479));
`endif
  endtask

  // gap: 0 none, >0 idle cycles before every byte after the first, <0 random
  task automatic run_load(input logic [14:0] base, input logic [15:0] n,
                          input int gap, input bit poke);
    logic [7:0]  bytes[$];
    logic [7:0]  b;
    logic [14:0] ea;
    int nb, bidx, burst, widx, cyc, hold, limit;
    bit fin, done_next, exp_rdy, wrote;
    nb = (int'(n) + 7) / 8;
    for (int i = 0; i < nb; i++) bytes.push_back(8'($urandom));
    bidx = 0; burst = 0; widx = 0; cyc = 0; hold = 0; fin = 0;
    limit = 4 * int'(n) + nb * ((gap > 0 ? gap : 4) + 4) + 50;
    @(negedge clk);
    start = 1'b1; base_addr = base; len = n; s_valid = 1'b0;
    done_next = (n == 16'd0);
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < limit) begin
      chk("busy", busy, 1);
      chk("done", done, done_next);
      chk("wr_en", wr_en, burst > 0);
      exp_rdy = (burst == 0) && (bidx < nb) && !done_next;
      chk("s_ready", s_ready, exp_rdy);
      wrote = 0;
      if (burst > 0) begin
        ea = base + 15'(widx);
        b  = bytes[widx / 8];
        chk("wr_addr", wr_addr, ea);
        chk("wr_data", wr_data, b[7 - (widx % 8)]);
        widx++;
        burst--;
        wrote = 1;
      end
      if (done_next) fin = 1;
      done_next = wrote && (widx == int'(n));
      // source side for the coming edge
      s_data  = 8'($urandom);
      s_valid = 1'($urandom);
      if (bidx < nb) begin
        if (gap < 0) begin
          s_valid = ($urandom_range(0, 2) != 0);
        end else if (hold > 0) begin
          s_valid = 1'b0;
          if (exp_rdy) hold--;
        end else begin
          s_valid = 1'b1;
        end
        if (s_valid) s_data = bytes[bidx];
        if (s_valid && exp_rdy) begin
          bidx++;
          burst = (int'(n) - 8 * (bidx - 1) < 8) ? int'(n) - 8 * (bidx - 1) : 8;
          hold  = (gap > 0) ? gap : 0;
        end
      end
      start = 1'b0;
      if (poke && cyc == 3) begin
        start     = 1'b1;
        base_addr = 15'($urandom);
        len       = 16'($urandom_range(0, 64));
      end
      drive_y();
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    s_valid = 1'b0;
    if (!fin) chk("timeout", 0, 1);
    chk("bytes_used", bidx, nb);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_wr_en", wr_en, 0);
    chk("idle_s_ready", s_ready, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    s_data = '0; s_valid = 1'b0;
    drive_y();
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    // 0xA5 to address 0 with a fixed byte
    @(negedge clk);
    start = 1'b1; base_addr = 15'd0; len = 16'd8;
    @(negedge clk);
    start = 1'b0;
    chk("a5_ready", s_ready, 1);
    s_valid = 1'b1; s_data = 8'hA5;
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] pat;
      pat = 8'hA5;
      chk("a5_we", wr_en, 1);
      chk("a5_addr", wr_addr, i);
      chk("a5_data", wr_data, pat[7 - i]);
      chk("a5_noready", s_ready, 0);
      @(negedge clk);
    end
    chk("a5_done", done, 1);
    chk("a5_done_we", wr_en, 0);
    @(negedge clk);
    s_valid = 1'b0;
    chk("a5_busy_off", busy, 0);

    // address wrap with a partially used last byte
    run_load(15'd32764, 16'd12, 0, 0);
    // 5-cycle source gap between bytes
    run_load(15'd200, 16'd16, 5, 0);
    // zero-length load
    run_load(15'($urandom), 16'd0, 0, 0);
    // start pulsed mid-load is ignored
    run_load(15'd4000, 16'd8, 0, 1);

    // reset while writing, then a normal load
    @(negedge clk);
    start = 1'b1; base_addr = 15'd100; len = 16'd8;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = 8'h3C;
    @(negedge clk);
    s_valid = 1'b0;
    chk("rw_we", wr_en, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rw_we0", wr_en, 0);
    chk("rw_ready0", s_ready, 0);
    chk("rw_busy0", busy, 0);
    chk("rw_done0", done, 0);
    chk("rw_addr0", wr_addr, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rw_idle_done", done, 0);
    chk("rw_idle_busy", busy, 0);
    run_load(15'd100, 16'd8, 0, 0);

    // random loads
    for (int k = 0; k < 8; k++)
      run_load(15'($urandom), 16'($urandom_range(1, 45)), -1, 0);
    run_load(15'd32700, 16'd300, -1, 0);

`ifdef TITLE_LOAD_VBLANK_EN
    @(negedge clk);
    y = 11'd100;
    start = 1'b1; base_addr = 15'd0; len = 16'd8;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = 8'hFF;
    @(negedge clk);
    s_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("vb_stall_we", wr_en, 0);
      chk("vb_stall_addr", wr_addr, 0);
      chk("vb_stall_ready", s_ready, 0);
      @(negedge clk);
    end
    y = 11'd480;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk("vb_we", wr_en, 1);
      chk("vb_addr", wr_addr, i);
      chk("vb_data", wr_data, 1);
      @(negedge clk);
    end
    chk("vb_done", done, 1);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
